fifo_burst_drain: RTL and testbench

Downstream consumer of the parameterized FIFO. Pops words from the FIFO read port and re-emits them on a valid/ready stream, grouped into bursts of BURST words with a last marker. A timeout flushes partial bursts. A 2-entry output buffer absorbs the FIFO's 1-cycle read latency so the stream sustains 1 word/cycle.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_skid_buf2.sv | 64 ++++++
 rtl/fifo_burst_drain.sv | 109 ++++++++++
 tb/tb_fifo_burst_drain.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO burst drain slice.
// State encoding, level width and buffer entry layout.
package fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int LEVEL_W = $clog2(DEPTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic                 last;
    logic [WIDTH_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry valid/ready buffer that soaks up the FIFO read latency.
// Head entry drives the stream directly from registers.
module fifo_skid_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_last,
  input  logic             m_ready,
  output logic [1:0]       occ,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  logic [WIDTH:0] e0;
  logic [WIDTH:0] e1;
  logic [WIDTH:0] w;
  logic           pop;

  assign w       = {wr_last, wr_data};
  assign m_valid = occ != 2'd0;
  assign pop     = m_valid && m_ready;
  assign m_last  = e0[WIDTH];
  assign m_data  = e0[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      unique case ({wr_valid, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= w;
          else e1 <= w;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            e0 <= w;
          end else begin
            e0 <= e1;
            e1 <= w;
          end
        end
        default: ;
      endcase
    end
  end

  // The read credit upstream must keep a write off a full buffer.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst)
    wr_valid |-> occ != 2'd2
  ) else $error("skid buffer write while full");

endmodule

// File: rtl/fifo_burst_drain.sv
// Pops FIFO words and re-emits them as BURST-sized stream bursts.
// Partial bursts are flushed after TIMEOUT idle cycles.
module fifo_burst_drain
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         fifo_rd_en,
  input  logic [WIDTH-1:0]             fifo_dout,
  input  logic                         fifo_empty,
  input  logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_data,
  output logic                         m_last,
  output logic                         burst_active,
  output logic [15:0]                  bursts_done
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [TW-1:0]   idle_timer;
  logic [LW-1:0]   reads_left;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      occ;
  logic            pop;
  logic [2:0]      credit;
  logic            lvl_nz;

  assign pop    = m_valid && m_ready;
  assign lvl_nz = fifo_level != '0;
  // Slots still claimed after this edge; a new read needs one free.
  assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  assign fifo_rd_en = (state == RUN)
                   && (reads_left != '0)
                   && !fifo_empty
                   && (credit < 3'd2);

  assign burst_active = state != IDLE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      idle_timer    <= '0;
      reads_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      bursts_done   <= 16'd0;
    end else begin
      inflight      <= fifo_rd_en;
      inflight_last <= fifo_rd_en && (reads_left == LW'(1));
      unique case (state)
        IDLE: begin
          if (!lvl_nz) idle_timer <= '0;
          else if (idle_timer != TW'(TIMEOUT))
            idle_timer <= idle_timer + TW'(1);
          if (fifo_level >= LW'(BURST)) begin
            state      <= RUN;
            reads_left <= LW'(BURST);
            idle_timer <= '0;
          end else if (lvl_nz &&
                       idle_timer == TW'(TIMEOUT - 1)) begin
            state      <= RUN;
            reads_left <= fifo_level;
            idle_timer <= '0;
          end
        end
        RUN: begin
          if (fifo_rd_en) begin
            reads_left <= reads_left - LW'(1);
            if (reads_left == LW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state       <= IDLE;
            bursts_done <= bursts_done + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(inflight),
    .wr_data (fifo_dout),
    .wr_last (inflight_last),
    .m_ready (m_ready),
    .occ     (occ),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last)
  );

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: FIFO model, scoreboard, directed tests.
// Outputs are observed on the falling edge, stimulus at posedge+2.
module tb_fifo_burst_drain;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;
  localparam int BURST   = 4;
  localparam int TIMEOUT = 16;
  localparam int LW      = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_empty = 1'b1;
  logic [LW-1:0]    fifo_level = '0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             burst_active;
  logic [15:0]      bursts_done;

  always #5 clk = ~clk;

  fifo_burst_drain #(
    .WIDTH(WIDTH), .DEPTH(DEPTH),
    .BURST(BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_level  (fifo_level),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .burst_active(burst_active),
    .bursts_done (bursts_done)
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input bit ok, input string nm,
                              input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endfunction

  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_d = '0;
  logic             fifo_clr = 1'b0;
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exp_q[$];
  int               cyc = 0;

  // FIFO with registered read data, one cycle after the pop.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (fifo_clr) begin
      fq.delete();
      exp_q.delete();
    end else begin
      if (fifo_rd_en === 1'b1 && fq.size() > 0)
        fifo_dout <= fq.pop_front();
      if (wr_en) begin
        fq.push_back(wr_d);
        exp_q.push_back(wr_d);
      end
    end
    fifo_level <= LW'(fq.size());
    fifo_empty <= (fq.size() == 0);
  end

  int               rd_log[$];
  int               hs_cyc[$];
  logic [WIDTH-1:0] hs_dat[$];
  bit               hs_lst[$];

  int               popped, delivered, since_last, bursts_m;
  logic             prev_stall;
  logic [WIDTH-1:0] prev_d;
  logic             prev_l;

  // Per-cycle scoreboard: what is seen here happens at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      popped = 0;
      delivered = 0;
      since_last = 0;
      bursts_m = 0;
      prev_stall = 1'b0;
    end else begin
      chk(bursts_done == bursts_m[15:0], "bursts_done",
          bursts_done, bursts_m[15:0]);
      if (prev_stall)
        chk(m_valid && m_data == prev_d && m_last == prev_l,
            "hold_stable", {m_valid, m_last, m_data},
            {1'b1, prev_l, prev_d});
      if (m_valid)
        chk(burst_active, "active_with_valid", burst_active, 1);
      if (fifo_rd_en) begin
        chk(!fifo_empty, "rd_on_empty", fifo_empty, 0);
        popped++;
        rd_log.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        delivered++;
        since_last++;
        chk(exp_q.size() > 0, "sb_nonempty", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          chk(m_data == e, "data_order", m_data, e);
        end
        hs_cyc.push_back(cyc);
        hs_dat.push_back(m_data);
        hs_lst.push_back(m_last);
        if (m_last) begin
          chk(since_last <= BURST, "burst_len", since_last, BURST);
          since_last = 0;
          bursts_m++;
        end else begin
          chk(since_last < BURST, "missing_last", since_last, BURST);
        end
      end
      chk(popped - delivered <= 2, "credit",
          popped - delivered, 2);
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    hs_cyc.delete();
    hs_dat.delete();
    hs_lst.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wr_en = 1'b0;
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
    chk(m_valid == 1'b0, "rst_m_valid", m_valid, 0);
    chk(fifo_rd_en == 1'b0, "rst_rd_en", fifo_rd_en, 0);
    chk(burst_active == 1'b0, "rst_active", burst_active, 0);
    chk(bursts_done == 16'd0, "rst_bursts", bursts_done, 0);
    chk(m_data == '0 && m_last == 1'b0, "rst_data",
        {m_last, m_data}, 0);
    step();
    rst = 1'b1;
  endtask

  task automatic wr_seq(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_d = base + WIDTH'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic run_idle(input bit tog, input int budget);
    int n;
    n = 0;
    wr_en = 1'b0;
    while (!(!burst_active && fifo_level == '0 &&
             exp_q.size() == 0) && n < budget) begin
      if (tog) m_ready = !m_ready;
      step();
      n++;
    end
    chk(n < budget, "idle_timeout", n, budget);
    m_ready = 1'b1;
  endtask

  task automatic check_seq(input string nm,
                           input logic [WIDTH-1:0] base,
                           input int n, input int per);
    chk(hs_dat.size() == n, {nm, "_count"}, hs_dat.size(), n);
    for (int i = 0; i < n && i < hs_dat.size(); i++) begin
      chk(hs_dat[i] == base + WIDTH'(i), {nm, "_data"},
          hs_dat[i], base + WIDTH'(i));
      chk(hs_lst[i] == ((i + 1) % per == 0), {nm, "_last"},
          hs_lst[i], (i + 1) % per == 0);
    end
  endtask

  initial begin
    int first_wr;
    int lasts;
    int b0;
    int n;

    do_reset();

    // 1: full burst at full rate
    clear_logs();
    m_ready = 1'b1;
    wr_seq(8'h11, 4);
    run_idle(1'b0, 60);
    check_seq("t1", 8'h11, 4, 4);
    chk(rd_log.size() == 4, "t1_rd_count", rd_log.size(), 4);
    if (rd_log.size() == 4 && hs_cyc.size() == 4) begin
      chk(rd_log[3] - rd_log[0] == 3, "t1_rd_back2back",
          rd_log[3] - rd_log[0], 3);
      chk(hs_cyc[0] - rd_log[0] == 2, "t1_latency",
          hs_cyc[0] - rd_log[0], 2);
      chk(hs_cyc[3] - hs_cyc[0] == 3, "t1_out_back2back",
          hs_cyc[3] - hs_cyc[0], 3);
    end
    chk(bursts_done == 16'd1, "t1_bursts", bursts_done, 1);

    // 2: partial burst flushed by timeout
    clear_logs();
    wr_en = 1'b1;
    wr_d = 8'hA0;
    step();
    first_wr = cyc;
    wr_seq(8'hA1, 2);
    run_idle(1'b0, 60);
    check_seq("t2", 8'hA0, 3, 3);
    chk(rd_log.size() == 3, "t2_rd_count", rd_log.size(), 3);
    if (rd_log.size() > 0)
      chk(rd_log[0] - first_wr == TIMEOUT, "t2_timeout",
          rd_log[0] - first_wr, TIMEOUT);
    chk(bursts_done == 16'd2, "t2_bursts", bursts_done, 2);

    // 3: eight words with m_ready toggling
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_d = WIDTH'(i);
      m_ready = !m_ready;
      step();
    end
    run_idle(1'b1, 100);
    check_seq("t3", 8'h00, 8, 4);
    chk(bursts_done == 16'd4, "t3_bursts", bursts_done, 4);

    // 4: long stall mid-burst
    clear_logs();
    m_ready = 1'b0;
    wr_seq(8'h31, 4);
    for (int i = 0; i < 12; i++) step();
    chk(rd_log.size() == 2, "t4_stall_reads", rd_log.size(), 2);
    chk(hs_dat.size() == 0, "t4_no_output", hs_dat.size(), 0);
    chk(m_valid && m_data == 8'h31, "t4_head",
        {m_valid, m_data}, {1'b1, 8'h31});
    m_ready = 1'b1;
    run_idle(1'b0, 40);
    check_seq("t4", 8'h31, 4, 4);
    chk(rd_log.size() == 4, "t4_rd_total", rd_log.size(), 4);
    chk(bursts_done == 16'd5, "t4_bursts", bursts_done, 5);

    // 5: reset in the middle of a burst
    clear_logs();
    wr_seq(8'h41, 4);
    n = 0;
    while (rd_log.size() == 0 && n < 20) begin
      step();
      n++;
    end
    chk(n < 20, "t5_start_timeout", n, 20);
    step();
    do_reset();
    clear_logs();
    wr_seq(8'h51, 4);
    run_idle(1'b0, 60);
    check_seq("t5", 8'h51, 4, 4);
    chk(bursts_done == 16'd1, "t5_bursts", bursts_done, 1);

    // 6: random traffic
    clear_logs();
    b0 = bursts_done;
    for (int i = 0; i < 500; i++) begin
      wr_en = ($urandom_range(0, 1) == 1) && (fifo_level < LW'(DEPTH));
      wr_d = WIDTH'($urandom);
      m_ready = $urandom_range(0, 9) < 7;
      step();
    end
    run_idle(1'b0, 200);
    lasts = 0;
    foreach (hs_lst[i]) if (hs_lst[i]) lasts++;
    chk(int'(bursts_done) - b0 == lasts, "t6_last_count",
        int'(bursts_done) - b0, lasts);
    chk(exp_q.size() == 0, "t6_drained", exp_q.size(), 0);
    chk(hs_dat.size() > 50, "t6_traffic", hs_dat.size(), 51);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
